// File: rtl/trigger_router.sv
// trigger_router: selects one of several raw trigger sources and routes it
// to a single registered trigger output, either as a straight passthrough or
// as an armed one-shot pulse of programmable width followed by a holdoff.
//
// Optional build macro:
//   TRIGGER_ROUTER_SYNC_EN - every I_src bit passes through a 2-flop
//                            synchroniser before selection (+2 cycles on all
//                            source-to-O_trig latencies). Undefined by default,
//                            in which case I_src is used directly.
//
// One-shot state machine (I_mode == 1):
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | not armed, O_trig low; arms when I_arm is high
//   ST_ARMED   | waiting for a rising edge on the selected source
//   ST_PULSE   | O_trig high for max(I_pulse_width,1) cycles
//   ST_HOLDOFF | O_trig low, dead time of I_holdoff cycles, edges ignored
//
// Passthrough (mode 0) and disabled (modes 2/3) hold the machine in ST_IDLE.
// Any change of I_mode forces ST_IDLE and O_trig low on the next edge.

module trigger_router #(
    parameter int pNUM_SRC  = 4,
    parameter int pCNT_BITS = 16,
    parameter int pLED_BITS = 23
) (
    input  logic                        trace_clk_in,
    input  logic                        reset_pin,
    input  logic [pNUM_SRC-1:0]         I_src,
    input  logic [$clog2(pNUM_SRC)-1:0] I_sel,
    input  logic [1:0]                  I_mode,
    input  logic                        I_arm,
    input  logic [pCNT_BITS-1:0]        I_pulse_width,
    input  logic [pCNT_BITS-1:0]        I_holdoff,
    input  logic                        I_clr_count,
    output logic                        O_trig,
    output logic                        O_armed,
    output logic                        O_capturing,
    output logic [7:0]                  O_fire_count,
    output logic                        O_led_alive
);

    localparam int SEL_W = $clog2(pNUM_SRC);

    localparam logic [1:0] MODE_PASS    = 2'd0;
    localparam logic [1:0] MODE_ONESHOT = 2'd1;

    localparam logic [pCNT_BITS-1:0] CNT_ZERO = '0;
    localparam logic [pCNT_BITS-1:0] CNT_ONE  = {{(pCNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [pLED_BITS-1:0] LED_ONE  = {{(pLED_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_PULSE   = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_trig;
    logic                   r_armed;
    logic                   r_capturing;
    logic [pCNT_BITS-1:0]   r_cnt;
    logic [pCNT_BITS-1:0]   r_holdoff_lat;
    logic                   r_src_q;
    logic [1:0]             r_mode_q;
    logic [7:0]             r_fire_count;
    logic [pLED_BITS-1:0]   r_led_cnt;

    logic [pNUM_SRC-1:0]    w_src_vec;
    logic                   w_sel_src;
    logic                   w_rise;
    logic                   w_mode_chg;
    logic                   w_fire;
    logic [pCNT_BITS-1:0]   w_pw_m1;

`ifdef TRIGGER_ROUTER_SYNC_EN
    logic [pNUM_SRC-1:0]    r_sync1;
    logic [pNUM_SRC-1:0]    r_sync2;

    // Two-flop synchroniser on every raw source bit.
    always_ff @(posedge trace_clk_in or posedge reset_pin) begin
        if (reset_pin) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= I_src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src_vec = r_sync2;
`else
    assign w_src_vec = I_src;
`endif

    // Source mux; select codes beyond the last source fall back to bit 0.
    always_comb begin
        w_sel_src = w_src_vec[0];
        for (int i = 1; i < pNUM_SRC; i++) begin
            if (I_sel == SEL_W'(i)) begin
                w_sel_src = w_src_vec[i];
            end
        end
    end

    assign w_rise     = w_sel_src & ~r_src_q;
    assign w_mode_chg = (I_mode != r_mode_q);

    // Pulse counter reload: a width of 0 behaves as 1, so the terminal
    // count is reached after max(width,1) cycles in ST_PULSE.
    assign w_pw_m1 = (I_pulse_width == CNT_ZERO) ? CNT_ZERO : (I_pulse_width - CNT_ONE);

    // A firing is exactly the ARMED -> PULSE transition of the state machine.
    assign w_fire = (I_mode == MODE_ONESHOT) && !w_mode_chg &&
                    (r_state == ST_ARMED) && I_arm && w_rise;

    // Delayed copies of the selected source and the mode for edge/change detection.
    always_ff @(posedge trace_clk_in or posedge reset_pin) begin
        if (reset_pin) begin
            r_src_q  <= 1'b0;
            r_mode_q <= MODE_PASS;
        end else begin
            r_src_q  <= w_sel_src;
            r_mode_q <= I_mode;
        end
    end

    // Routing state machine with registered trigger/status outputs.
    always_ff @(posedge trace_clk_in or posedge reset_pin) begin
        if (reset_pin) begin
            r_state       <= ST_IDLE;
            r_trig        <= 1'b0;
            r_armed       <= 1'b0;
            r_capturing   <= 1'b0;
            r_cnt         <= CNT_ZERO;
            r_holdoff_lat <= CNT_ZERO;
        end else if (w_mode_chg) begin
            r_state     <= ST_IDLE;
            r_trig      <= 1'b0;
            r_armed     <= 1'b0;
            r_capturing <= 1'b0;
            r_cnt       <= CNT_ZERO;
        end else if (I_mode == MODE_PASS) begin
            r_state     <= ST_IDLE;
            r_trig      <= w_sel_src;
            r_armed     <= 1'b0;
            r_capturing <= 1'b0;
        end else if (I_mode != MODE_ONESHOT) begin
            r_state     <= ST_IDLE;
            r_trig      <= 1'b0;
            r_armed     <= 1'b0;
            r_capturing <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_trig      <= 1'b0;
                    r_capturing <= 1'b0;
                    if (I_arm) begin
                        r_state <= ST_ARMED;
                        r_armed <= 1'b1;
                    end else begin
                        r_armed <= 1'b0;
                    end
                end

                ST_ARMED: begin
                    if (!I_arm) begin
                        r_state <= ST_IDLE;
                        r_armed <= 1'b0;
                    end else if (w_rise) begin
                        // Width and holdoff are captured here so that later
                        // register writes cannot stretch or cut this pulse.
                        r_state       <= ST_PULSE;
                        r_trig        <= 1'b1;
                        r_armed       <= 1'b0;
                        r_capturing   <= 1'b1;
                        r_cnt         <= w_pw_m1;
                        r_holdoff_lat <= I_holdoff;
                    end
                end

                ST_PULSE: begin
                    if (r_cnt == CNT_ZERO) begin
                        r_trig <= 1'b0;
                        if (r_holdoff_lat == CNT_ZERO) begin
                            r_state     <= ST_IDLE;
                            r_capturing <= 1'b0;
                        end else begin
                            r_state <= ST_HOLDOFF;
                            r_cnt   <= r_holdoff_lat - CNT_ONE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end

                ST_HOLDOFF: begin
                    r_trig <= 1'b0;
                    if (r_cnt == CNT_ZERO) begin
                        r_state     <= ST_IDLE;
                        r_capturing <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_trig      <= 1'b0;
                    r_armed     <= 1'b0;
                    r_capturing <= 1'b0;
                end
            endcase
        end
    end

    // Saturating firing counter; a clear wins over a same-cycle firing.
    always_ff @(posedge trace_clk_in or posedge reset_pin) begin
        if (reset_pin) begin
            r_fire_count <= 8'd0;
        end else if (I_clr_count) begin
            r_fire_count <= 8'd0;
        end else if (w_fire && (r_fire_count != 8'hFF)) begin
            r_fire_count <= r_fire_count + 8'd1;
        end
    end

    // Clock-alive counter: runs while the trigger is low, freezes while high.
    always_ff @(posedge trace_clk_in or posedge reset_pin) begin
        if (reset_pin) begin
            r_led_cnt <= '0;
        end else if (!r_trig) begin
            r_led_cnt <= r_led_cnt + LED_ONE;
        end
    end

    assign O_trig       = r_trig;
    assign O_armed      = r_armed;
    assign O_capturing  = r_capturing;
    assign O_fire_count = r_fire_count;
    assign O_led_alive  = r_led_cnt[pLED_BITS-1];

endmodule
